mov_fetch_sequencer: RTL and testbench

//  Fetch/issue controller for the 8-bit MOV-only core. Drives the PC into the

---
 rtl/mov_fetch_sequencer_pkg.sv | 26 ++
 rtl/mov_fetch_sequencer_decoder.sv | 19 +
 rtl/mov_fetch_sequencer.sv | 138 +++++++++++++
 tb/tb_mov_fetch_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mov_fetch_sequencer_pkg.sv
// Shared definitions for the MOV-only core fetch/issue sequencer:
// state encoding, instruction field positions and the retired-counter ceiling.
package mov_fetch_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_ISSUE  = 3'd3,
      ST_HALT   = 3'd4
   } state_e;

   // Instruction layout: [7:4] = Rd, [3:0] = Rs
   localparam int RD_MSB = 7;
   localparam int RD_LSB = 4;
   localparam int RS_MSB = 3;
   localparam int RS_LSB = 0;

   localparam logic [7:0] RETIRED_MAX = 8'hFF;

   // Saturating increment for the retired-instruction counter
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == RETIRED_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/mov_fetch_sequencer_decoder.sv
// Combinational field decoder: splits the IR into Rd/Rs and flags Rd==Rs moves,
// which have no architectural effect and are retired without issue.
module mov_field_decoder
   import mov_fetch_sequencer_pkg::*;
#(
   parameter int INSTR_WIDTH = 8,
   parameter int REG_AW      = 4
) (
   input  logic [INSTR_WIDTH-1:0] ir,
   output logic [REG_AW-1:0]      dst,
   output logic [REG_AW-1:0]      src,
   output logic                   is_nop
);

   assign dst    = ir[RD_MSB:RD_LSB];
   assign src    = ir[RS_MSB:RS_LSB];
   assign is_nop = (dst == src);

endmodule

// File: rtl/mov_fetch_sequencer.sv
// Fetch/issue controller: walks the program from address 0 to PROG_LEN-1,
// issuing one register-move command per instruction over valid/ready.
module mov_fetch_sequencer
   import mov_fetch_sequencer_pkg::*;
#(
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 8,
   parameter int REG_AW      = 4,
   parameter int PROG_LEN    = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   output logic [PC_WIDTH-1:0]    pc,
   input  logic [INSTR_WIDTH-1:0] instr_code,
   output logic                   mov_valid,
   output logic [REG_AW-1:0]      mov_dst,
   output logic [REG_AW-1:0]      mov_src,
   input  logic                   mov_ready,
   output logic                   busy,
   output logic                   halted,
   output logic [7:0]             retired
);

   // Last address compared one bit wider so a full-range program stops at all-ones
   localparam logic [PC_WIDTH:0]   LAST_PC = (PC_WIDTH + 1)'(PROG_LEN - 1);
   localparam logic [PC_WIDTH-1:0] PC_ONE  = PC_WIDTH'(1);

   state_e                 state_q,     state_d;
   logic [PC_WIDTH-1:0]    pc_q,        pc_d;
   logic [INSTR_WIDTH-1:0] ir_q,        ir_d;
   logic                   mov_valid_q, mov_valid_d;
   logic [REG_AW-1:0]      mov_dst_q,   mov_dst_d;
   logic [REG_AW-1:0]      mov_src_q,   mov_src_d;
   logic [7:0]             retired_q,   retired_d;

   logic [REG_AW-1:0]      dec_dst;
   logic [REG_AW-1:0]      dec_src;
   logic                   dec_is_nop;
   logic                   at_last;

   mov_field_decoder #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .REG_AW      (REG_AW)
   ) u_decoder (
      .ir     (ir_q),
      .dst    (dec_dst),
      .src    (dec_src),
      .is_nop (dec_is_nop)
   );

   assign at_last = ({1'b0, pc_q} == LAST_PC);

   // NOTE: every signal gets its hold value before the case so no path infers a latch.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      mov_valid_d = mov_valid_q;
      mov_dst_d   = mov_dst_q;
      mov_src_d   = mov_src_q;
      retired_d   = retired_q;

      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               state_d   = ST_FETCH;
               pc_d      = '0;
               retired_d = '0;
            end
         end
         ST_FETCH: begin
            ir_d    = instr_code;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            mov_dst_d = dec_dst;
            mov_src_d = dec_src;
            if (dec_is_nop) begin
               retired_d = sat_inc(retired_q);
               if (at_last) begin
                  state_d = ST_HALT;
               end else begin
                  pc_d    = pc_q + PC_ONE;
                  state_d = ST_FETCH;
               end
            end else begin
               mov_valid_d = 1'b1;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // Command fields stay frozen until the datapath accepts
            if (mov_ready) begin
               mov_valid_d = 1'b0;
               retired_d   = sat_inc(retired_q);
               if (at_last) begin
                  state_d = ST_HALT;
               end else begin
                  pc_d    = pc_q + PC_ONE;
                  state_d = ST_FETCH;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         pc_q        <= '0;
         ir_q        <= '0;
         mov_valid_q <= 1'b0;
         mov_dst_q   <= '0;
         mov_src_q   <= '0;
         retired_q   <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         mov_valid_q <= mov_valid_d;
         mov_dst_q   <= mov_dst_d;
         mov_src_q   <= mov_src_d;
         retired_q   <= retired_d;
      end
   end

   assign pc        = pc_q;
   assign mov_valid = mov_valid_q;
   assign mov_dst   = mov_dst_q;
   assign mov_src   = mov_src_q;
   assign retired   = retired_q;
   assign busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_ISSUE);
   assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_mov_fetch_sequencer.sv
// Directed bench for mov_fetch_sequencer: program run, stall, NOP, reset,
// restart and a narrow-PC full-range program on a second instance.
module tb_mov_fetch_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic mov_ready = 1'b1;
   always #5 clk = ~clk;

   // Instance A: PC_WIDTH=8, PROG_LEN=3
   logic [7:0] mem_a [256];
   logic [7:0] pc;
   logic [7:0] instr_code;
   logic       mov_valid;
   logic [3:0] mov_dst;
   logic [3:0] mov_src;
   logic       busy;
   logic       halted;
   logic [7:0] retired;
   assign instr_code = mem_a[pc];

   mov_fetch_sequencer #(
      .PC_WIDTH (8), .INSTR_WIDTH (8), .REG_AW (4), .PROG_LEN (3)
   ) dut (
      .clk (clk), .reset (reset), .start (start), .pc (pc),
      .instr_code (instr_code), .mov_valid (mov_valid), .mov_dst (mov_dst),
      .mov_src (mov_src), .mov_ready (mov_ready), .busy (busy),
      .halted (halted), .retired (retired)
   );

   // Instance B: PC_WIDTH=2, PROG_LEN=4 (full address range)
   logic       start_b = 1'b0;
   logic       ready_b = 1'b1;
   logic [7:0] mem_b [4];
   logic [1:0] pc_b;
   logic [7:0] instr_b;
   logic       valid_b;
   logic [3:0] dst_b;
   logic [3:0] src_b;
   logic       busy_b;
   logic       halted_b;
   logic [7:0] retired_b;
   assign instr_b = mem_b[pc_b];

   mov_fetch_sequencer #(
      .PC_WIDTH (2), .INSTR_WIDTH (8), .REG_AW (4), .PROG_LEN (4)
   ) dut_b (
      .clk (clk), .reset (reset), .start (start_b), .pc (pc_b),
      .instr_code (instr_b), .mov_valid (valid_b), .mov_dst (dst_b),
      .mov_src (src_b), .mov_ready (ready_b), .busy (busy_b),
      .halted (halted_b), .retired (retired_b)
   );

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] cmd_q [8];
   logic [7:0] pc_at [8];
   logic [1:0] pcb_at [8];
   int         edges;
   int         ncmd;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pulses start on instance A and records every issued command until HALT
   task automatic run_a(output int n_edges, output int n_cmd);
      n_edges = 0;
      n_cmd   = 0;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      n_edges = 1;
      while (!halted && n_edges < 60) begin
         tick();
         n_edges++;
         if (mov_valid && n_cmd < 8) begin
            cmd_q[n_cmd] = {mov_dst, mov_src};
            pc_at[n_cmd] = pc;
            n_cmd++;
         end
      end
      chk("run_reaches_halt", halted, 1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
      mem_a[0] = 8'h5A;
      mem_a[1] = 8'hA6;
      mem_a[2] = 8'h65;
      mem_b[0] = 8'h12;
      mem_b[1] = 8'h34;
      mem_b[2] = 8'h56;
      mem_b[3] = 8'h78;

      // Reset state
      tick();
      tick();
      chk("rst_pc", pc, 0);
      chk("rst_valid", mov_valid, 0);
      chk("rst_dst", mov_dst, 0);
      chk("rst_src", mov_src, 0);
      chk("rst_busy", busy, 0);
      chk("rst_halted", halted, 0);
      chk("rst_retired", retired, 0);
      reset = 1'b1;
      tick();
      chk("idle_no_start_busy", busy, 0);

      // Plain run with ready held high, stepped cycle by cycle
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("r1_fetch_busy", busy, 1);
      chk("r1_fetch_pc", pc, 0);
      chk("r1_fetch_valid", mov_valid, 0);
      tick();
      chk("r1_decode_valid", mov_valid, 0);
      tick();
      chk("r1_c1_valid", mov_valid, 1);
      chk("r1_c1_dst", mov_dst, 4'h5);
      chk("r1_c1_src", mov_src, 4'hA);
      tick();
      chk("r1_c1_drop", mov_valid, 0);
      chk("r1_pc1", pc, 1);
      chk("r1_ret1", retired, 1);
      tick();
      tick();
      chk("r1_c2_valid", mov_valid, 1);
      chk("r1_c2_dst", mov_dst, 4'hA);
      chk("r1_c2_src", mov_src, 4'h6);
      tick();
      chk("r1_pc2", pc, 2);
      chk("r1_ret2", retired, 2);
      tick();
      tick();
      chk("r1_c3_valid", mov_valid, 1);
      chk("r1_c3_dst", mov_dst, 4'h6);
      chk("r1_c3_src", mov_src, 4'h5);
      tick();
      chk("r1_halted", halted, 1);
      chk("r1_busy_off", busy, 0);
      chk("r1_ret3", retired, 3);
      chk("r1_pc_last", pc, 2);
      chk("r1_valid_off", mov_valid, 0);
      tick();
      tick();
      chk("r1_halt_hold", halted, 1);
      chk("r1_halt_pc_hold", pc, 2);

      // Restart from HALT, stall the 2nd command for 4 cycles, start pulsed mid-stall
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("r2_restart_pc", pc, 0);
      chk("r2_restart_ret", retired, 0);
      chk("r2_restart_busy", busy, 1);
      tick();
      tick();
      chk("r2_c1_dst", mov_dst, 4'h5);
      tick();
      chk("r2_ret1", retired, 1);
      mov_ready = 1'b0;
      tick();
      tick();
      chk("r2_stall0_valid", mov_valid, 1);
      chk("r2_stall0_dst", mov_dst, 4'hA);
      chk("r2_stall0_src", mov_src, 4'h6);
      for (int k = 1; k < 4; k++) begin
         if (k == 2) start = 1'b1;
         tick();
         start = 1'b0;
         chk("r2_stall_valid", mov_valid, 1);
         chk("r2_stall_dst", mov_dst, 4'hA);
         chk("r2_stall_src", mov_src, 4'h6);
         chk("r2_stall_ret", retired, 1);
         chk("r2_stall_pc", pc, 1);
      end
      mov_ready = 1'b1;
      tick();
      chk("r2_accept_drop", mov_valid, 0);
      chk("r2_accept_ret", retired, 2);
      chk("r2_accept_pc", pc, 2);
      tick();
      tick();
      chk("r2_c3_dst", mov_dst, 4'h6);
      chk("r2_c3_src", mov_src, 4'h5);
      tick();
      chk("r2_halted", halted, 1);
      chk("r2_ret3", retired, 3);

      // NOP at address 1: not issued, still retired, one cycle shorter
      mem_a[1] = 8'h33;
      run_a(edges, ncmd);
      chk("nop_edges", edges, 9);
      chk("nop_ncmd", ncmd, 2);
      chk("nop_cmd0", cmd_q[0], 8'h5A);
      chk("nop_cmd1", cmd_q[1], 8'h65);
      chk("nop_ret", retired, 3);
      chk("nop_pc", pc, 2);

      mem_a[1] = 8'hA6;
      run_a(edges, ncmd);
      chk("full_edges", edges, 10);
      chk("full_ncmd", ncmd, 3);
      chk("full_cmd0", cmd_q[0], 8'h5A);
      chk("full_cmd1", cmd_q[1], 8'hA6);
      chk("full_cmd2", cmd_q[2], 8'h65);
      chk("full_pc_at2", pc_at[2], 2);

      // Reset while ISSUE is stalled on the 2nd command
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      mov_ready = 1'b0;
      tick();
      tick();
      chk("rr_pre_valid", mov_valid, 1);
      chk("rr_pre_ret", retired, 1);
      reset = 1'b0;
      tick();
      chk("rr_valid", mov_valid, 0);
      chk("rr_busy", busy, 0);
      chk("rr_halted", halted, 0);
      chk("rr_pc", pc, 0);
      chk("rr_ret", retired, 0);
      chk("rr_dst", mov_dst, 0);
      reset = 1'b1;
      mov_ready = 1'b1;
      tick();
      chk("rr_idle", busy, 0);
      run_a(edges, ncmd);
      chk("rr_rerun_edges", edges, 10);
      chk("rr_rerun_ncmd", ncmd, 3);
      chk("rr_rerun_pc0", pc_at[0], 0);
      chk("rr_rerun_cmd0", cmd_q[0], 8'h5A);
      chk("rr_rerun_ret", retired, 3);

      // Narrow PC, full-range program: pc 0..3, halts at 3, no wrap
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      edges = 1;
      ncmd  = 0;
      while (!halted_b && edges < 60) begin
         tick();
         edges++;
         if (valid_b && ncmd < 8) begin
            pcb_at[ncmd] = pc_b;
            ncmd++;
         end
      end
      chk("b_halted", halted_b, 1);
      chk("b_edges", edges, 13);
      chk("b_ncmd", ncmd, 4);
      for (int i = 0; i < 4; i++) chk("b_pc_step", pcb_at[i], i);
      chk("b_ret", retired_b, 4);
      chk("b_pc_last", pc_b, 3);
      tick();
      tick();
      tick();
      chk("b_pc_no_wrap", pc_b, 3);
      chk("b_halt_hold", halted_b, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
